// File: rtl/apb_master_if.sv
// Bundle of the local command/response handshake and the APB bus seen by
// apb_master. The master modport is the initiator's view; the slave modport
// is the view of whatever sits on the other side (controller plus completer).
interface apb_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // Local command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // Local response channel
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_timeout;

    // APB bus
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  prdata, pready,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output prdata, pready,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master.sv
// APB initiator: turns single-beat local commands into APB transfers,
// honours pready wait states, and reports completion (with read data) or a
// timeout abort on a one-cycle response strobe.
module apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16   // max pready-low ACCESS cycles; 0 = wait forever
) (
    input  logic         clk,
    input  logic         reset,   // synchronous, active-low
    apb_master_if.master bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // The wait counter only has to reach TIMEOUT; a 1-bit counter is kept
    // when the timeout is disabled so the declarations stay legal.
    localparam int               CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit               TO_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Abort fires on the ACCESS cycle that would be the TIMEOUT-th low one,
    // i.e. when TIMEOUT-1 low cycles have already been counted.
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]        state;
    logic [1:0]        state_d;
    logic [CNT_W-1:0]  wait_cnt;
    logic              done;
    logic              abort;

    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_timeout_q;

    logic              accept;

    // Command handshake: only IDLE accepts, and never while reset is held.
    assign bus.cmd_ready = (state == ST_IDLE) && reset;
    assign accept        = (state == ST_IDLE) && bus.cmd_valid;

    // APB control strobes decode straight from the state register.
    assign bus.psel      = (state == ST_SETUP) || (state == ST_ACCESS);
    assign bus.penable   = (state == ST_ACCESS);
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_timeout = rsp_timeout_q;

    // Next-state decode; pready only matters in ACCESS.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d = state;
        done    = 1'b0;
        abort   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.pready) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else if (TO_EN && (wait_cnt == TO_LIM)) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, captured command, wait counter and response registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!reset) begin
            // NOTE: the address/data registers are reset too because they are
            // visible on the bus and must read as zero after reset.
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state <= state_d;

            // Command fields are frozen from SETUP until the next accept.
            if (accept) begin
                pwrite_q <= bus.cmd_write;
                paddr_q  <= bus.cmd_addr;
                pwdata_q <= bus.cmd_wdata;
            end

            // Count pready-low ACCESS cycles; saturate rather than wrap.
            if (state == ST_SETUP) begin
                wait_cnt <= '0;
            end else if ((state == ST_ACCESS) && !bus.pready && (wait_cnt != CNT_MAX)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            // One-cycle response; data is zero except for a completed read.
            rsp_valid_q   <= done || abort;
            rsp_timeout_q <= abort;
            rsp_rdata_q   <= (done && !pwrite_q) ? bus.prdata : '0;
        end
    end

endmodule
